fc_ctrl: RTL
============

Name: fc_ctrl

Overview:
- Layer-level sequencer for the fully-connected datapath; it is the initiator side of the FC AGU start/done/conf interface.
- Accepts one FC layer command and splits it into (out_blk × in_blk) AGU tasks, iterating input blocks innermost.
- Before each task it waits for the buffer loader to report the operand tile ready; after each task it releases the tile.
- It drives conf_is_new for the first input block of each output tile and pulses layer_done when the whole layer has finished.

Parameters:
- CNT_W, 8, width of block counters and AGU count fields.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cmd_valid  input  1  layer command valid
- cmd_ready  output  1  high only in IDLE
- cmd_mode  input  2  AGU mode for the whole layer
- cmd_in_blk  input  CNT_W  number of input blocks
- cmd_out_blk  input  CNT_W  number of output blocks
- cmd_idx_cnt  input  CNT_W  per-task idx count, passed to the AGU
- cmd_trip_cnt  input  CNT_W  per-task trip count, passed to the AGU
- buf_ready  input  1  level; operand tile for the current task is loaded
- buf_release  output  1  1-cycle pulse; current tile consumed
- agu_start  output  1  1-cycle task start pulse
- agu_done  input  1  task-done pulse from the AGU
- agu_conf_mode  output  2  latched cmd_mode
- agu_conf_idx_cnt  output  CNT_W  latched cmd_idx_cnt
- agu_conf_trip_cnt  output  CNT_W  latched cmd_trip_cnt
- agu_conf_is_new  output  1  high when in_idx==0 (first accumulation into this output tile)
- cur_in_idx  output  CNT_W  current input block index
- cur_out_idx  output  CNT_W  current output block index
- layer_done  output  1  1-cycle pulse; layer complete

Behaviour:
- Reset: state=IDLE. cmd_ready=1. agu_start, buf_release and layer_done =0. All conf outputs and indices =0. Reset mid-layer aborts immediately, with no done or release pulse.
- FSM states: IDLE, WAIT_BUF, START, RUN, NEXT, DONE.
- IDLE: cmd_ready=1. On cmd_valid at cycle T, latch all cmd fields and clear both indices.
  - If cmd_in_blk==0 or cmd_out_blk==0: go to DONE (layer_done at T+1, no AGU tasks).
  - Otherwise: go to WAIT_BUF at T+1.
- WAIT_BUF: wait for buf_ready=1, then go to START. If buf_ready is already high on entry, START is the next cycle.
- START: agu_start=1 for exactly one cycle, then go to RUN.
- RUN: wait for agu_done.
  - agu_done is ignored in every state except RUN; this includes a spurious done in the START cycle.
  - agu_done sampled at cycle D: go to NEXT at D+1.
- NEXT (one cycle): buf_release=1, and the indices advance.
  - If in_idx==in_blk-1: in_idx←0, out_idx←out_idx+1. Otherwise in_idx←in_idx+1.
  - If the finished task was the last one (in_idx==in_blk-1 and out_idx==out_blk-1): go to DONE, and the indices hold their final values.
  - Otherwise: go to WAIT_BUF. The earliest next agu_start is D+3.
- DONE (one cycle): layer_done=1, then go to IDLE. cmd_ready returns at the following cycle, so for the last task it is at D+3.
- Conf outputs are register-driven and stable from START until the NEXT that follows it. They change only on the index update in NEXT or on command accept.
- agu_conf_is_new = (cur_in_idx==0), registered together with the index.
- Index comparisons use CNT_W-bit unsigned arithmetic. in_blk=255 and out_blk=255 are legal (65025 tasks); there is no wrap beyond the final values.
- buf_release and agu_start are never high in the same cycle.
- cmd_valid is ignored outside IDLE.

Test Plan:
1. in_blk=2, out_blk=1, buf_ready tied 1, AGU done 4 cycles after start. Required: 2 agu_start pulses; is_new=1 then 0; 2 buf_release pulses; exactly one layer_done, 2 cycles after the second done.
2. in_blk=3, out_blk=2, idx_cnt=5, trip_cnt=7, mode=2. Required: 6 tasks in order (out,in) = (0,0)(0,1)(0,2)(1,0)(1,1)(1,2); is_new high on tasks 1 and 4; conf fields read 2/5/7 on every start.
3. buf_ready held low for 10 cycles after accept. Required: no agu_start while it is low; agu_start exactly 1 cycle after buf_ready rises.
4. in_blk=0, out_blk=4. Required: layer_done 1 cycle after accept; zero agu_start and zero buf_release pulses; cmd_ready back high the cycle after that.
5. agu_done injected during START and during WAIT_BUF. Required: both ignored; the task completes only on a done seen in RUN.
6. rst asserted during RUN of task 2 of 4. Required: next cycle shows IDLE, cmd_ready=1, indices 0, no layer_done; a new command then runs correctly from (0,0).

Source files
------------

// File: rtl/fc_ctrl.sv
// Layer sequencer for the fully-connected datapath: splits one layer command into
// out_blk x in_blk AGU tasks (input blocks innermost), handshaking with the buffer loader.
module fc_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [CNT_W-1:0] cmd_in_blk,
    input  logic [CNT_W-1:0] cmd_out_blk,
    input  logic [CNT_W-1:0] cmd_idx_cnt,
    input  logic [CNT_W-1:0] cmd_trip_cnt,
    input  logic             buf_ready,
    output logic             buf_release,
    output logic             agu_start,
    input  logic             agu_done,
    output logic [1:0]       agu_conf_mode,
    output logic [CNT_W-1:0] agu_conf_idx_cnt,
    output logic [CNT_W-1:0] agu_conf_trip_cnt,
    output logic             agu_conf_is_new,
    output logic [CNT_W-1:0] cur_in_idx,
    output logic [CNT_W-1:0] cur_out_idx,
    output logic             layer_done
);

    typedef enum logic [2:0] {StIdle, StWaitBuf, StStart, StRun, StNext, StDone} state_e;

    state_e state_q, state_d;

    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] in_blk_q, in_blk_d;
    logic [CNT_W-1:0] out_blk_q, out_blk_d;
    logic [CNT_W-1:0] idx_cnt_q, idx_cnt_d;
    logic [CNT_W-1:0] trip_cnt_q, trip_cnt_d;
    logic [CNT_W-1:0] in_idx_q, in_idx_d;
    logic [CNT_W-1:0] out_idx_q, out_idx_d;
    logic             is_new_q, is_new_d;

    logic last_in, last_task, cmd_empty;

    assign last_in   = (in_idx_q == in_blk_q - CNT_W'(1));
    assign last_task = last_in && (out_idx_q == out_blk_q - CNT_W'(1));
    assign cmd_empty = (cmd_in_blk == '0) || (cmd_out_blk == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cmd_valid) state_d = cmd_empty ? StDone : StWaitBuf;
            StWaitBuf: if (buf_ready) state_d = StStart;
            StStart:   state_d = StRun;
            StRun:     if (agu_done) state_d = StNext;
            StNext:    state_d = last_task ? StDone : StWaitBuf;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready   = (state_q == StIdle);
        agu_start   = (state_q == StStart);
        buf_release = (state_q == StNext);
        layer_done  = (state_q == StDone);
    end

    // Indices and conf fields only move on command accept or on the NEXT update.
    always_comb begin
        mode_d     = mode_q;
        in_blk_d   = in_blk_q;
        out_blk_d  = out_blk_q;
        idx_cnt_d  = idx_cnt_q;
        trip_cnt_d = trip_cnt_q;
        in_idx_d   = in_idx_q;
        out_idx_d  = out_idx_q;
        is_new_d   = is_new_q;
        if (state_q == StIdle && cmd_valid) begin
            mode_d     = cmd_mode;
            in_blk_d   = cmd_in_blk;
            out_blk_d  = cmd_out_blk;
            idx_cnt_d  = cmd_idx_cnt;
            trip_cnt_d = cmd_trip_cnt;
            in_idx_d   = '0;
            out_idx_d  = '0;
            is_new_d   = 1'b1;
        end else if (state_q == StNext && !last_task) begin
            if (last_in) begin
                in_idx_d  = '0;
                out_idx_d = out_idx_q + CNT_W'(1);
            end else begin
                in_idx_d = in_idx_q + CNT_W'(1);
            end
            is_new_d = last_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= '0;
            in_blk_q   <= '0;
            out_blk_q  <= '0;
            idx_cnt_q  <= '0;
            trip_cnt_q <= '0;
            in_idx_q   <= '0;
            out_idx_q  <= '0;
            is_new_q   <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            in_blk_q   <= in_blk_d;
            out_blk_q  <= out_blk_d;
            idx_cnt_q  <= idx_cnt_d;
            trip_cnt_q <= trip_cnt_d;
            in_idx_q   <= in_idx_d;
            out_idx_q  <= out_idx_d;
            is_new_q   <= is_new_d;
        end
    end

    assign agu_conf_mode     = mode_q;
    assign agu_conf_idx_cnt  = idx_cnt_q;
    assign agu_conf_trip_cnt = trip_cnt_q;
    assign agu_conf_is_new   = is_new_q;
    assign cur_in_idx        = in_idx_q;
    assign cur_out_idx       = out_idx_q;

endmodule
